// File: rtl/batcharger_pkg.sv
`default_nettype none
// ============================================================================
// Module      : batcharger_pkg
// Description : Shared types and constants for the battery-charger ADC
//               sequencer. Holds the sequencer state encoding, the analog mux
//               channel codes, the ADC width and the channel-rotation helper.
// Revision    : 1.0 - initial release
// ============================================================================
package batcharger_pkg;

    localparam int ADC_W = 8;
    localparam int BIT_W = $clog2(ADC_W);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SELECT  = 2'd1,
        CONVERT = 2'd2,
        STORE   = 2'd3
    } state_e;

    localparam logic [1:0] CH_V = 2'b00;
    localparam logic [1:0] CH_I = 2'b01;
    localparam logic [1:0] CH_T = 2'b10;

    // mask bit 0 = voltage, bit 1 = current, bit 2 = temperature
    function automatic logic ch_enabled(input logic [1:0] ch, input logic [2:0] mask);
        logic en_bit;
        case (ch)
            CH_V:    en_bit = mask[0];
            CH_I:    en_bit = mask[1];
            CH_T:    en_bit = mask[2];
            default: en_bit = 1'b0;
        endcase
        return en_bit;
    endfunction

    // First enabled channel strictly after cur in V -> I -> T -> V order.
    // cur itself is the last candidate, so a single enabled channel repeats.
    function automatic logic [1:0] next_channel(input logic [1:0] cur, input logic [2:0] mask);
        logic [1:0] cand;
        logic [1:0] pick;
        logic       found;
        cand  = cur;
        pick  = cur;
        found = 1'b0;
        for (int s = 0; s < 3; s++) begin
            cand = (cand >= CH_T) ? CH_V : cand + 2'd1;
            if (!found && ch_enabled(cand, mask)) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage
`default_nettype wire

// File: rtl/batcharger_sar_core.sv
`default_nettype none
// ============================================================================
// Module      : batcharger_sar_core
// Description : Successive-approximation engine. Walks a bit pointer from
//               MSB to LSB, presenting result|(1<<k) on the DAC and keeping
//               bit k when the comparator reports Vin >= Vdac.
// Ports       : clk, rst_n   - clock, async active-low reset
//               start        - begin a conversion (clears result, pointer=MSB)
//               clr          - abandon any conversion, discard partial result
//               comp         - comparator output for the current trial
//               dac          - trial code, 0 when no conversion is running
//               result       - accumulated code
//               done         - high during the LSB trial cycle
// Revision    : 1.0 - initial release
// ============================================================================
module batcharger_sar_core
    import batcharger_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clr,
    input  logic             comp,
    output logic [ADC_W-1:0] dac,
    output logic [ADC_W-1:0] result,
    output logic             done
);

    localparam logic [BIT_W-1:0] c_msb = BIT_W'(ADC_W - 1);
    localparam logic [ADC_W-1:0] c_one = ADC_W'(1);

    logic             active_q, active_d;
    logic [BIT_W-1:0] bit_q,    bit_d;
    logic [ADC_W-1:0] result_q, result_d;
    logic [ADC_W-1:0] w_trial;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            bit_q    <= c_msb;
            result_q <= '0;
        end else begin
            active_q <= active_d;
            bit_q    <= bit_d;
            result_q <= result_d;
        end
    end

    assign w_trial = result_q | (c_one << bit_q);

    always_comb begin
        active_d = active_q;
        bit_d    = bit_q;
        result_d = result_q;
        if (clr) begin
            active_d = 1'b0;
            bit_d    = c_msb;
            result_d = '0;
        end else if (start) begin
            active_d = 1'b1;
            bit_d    = c_msb;
            result_d = '0;
        end else if (active_q) begin
            // Keep the trial bit only when Vin >= Vdac
            result_d = comp ? w_trial : result_q;
            if (bit_q == '0) begin
                active_d = 1'b0;
            end else begin
                bit_d = bit_q - BIT_W'(1);
            end
        end
    end

    assign dac    = active_q ? w_trial : '0;
    assign result = result_q;
    assign done   = active_q && (bit_q == '0);

endmodule
`default_nettype wire

// File: rtl/batcharger_adc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : batcharger_adc_sequencer
// Description : Time-multiplexes one 8-bit SAR ADC across battery voltage,
//               current and temperature. Each conversion is SELECT (settle,
//               sample=1) -> CONVERT (8 SAR trials) -> STORE, then rotates to
//               the next enabled channel.
// Ports       : clk, rstz          - clock, async active-low reset
//               en                 - block enable
//               vmonen/imonen/tmonen - per-channel enables
//               comp               - comparator, 1 when Vin >= Vdac
//               chsel, sample, dac - analog mux select, S/H track, DAC code
//               eoc                - one-cycle end-of-conversion pulse
//               vbat, ibat, tbat   - stored codes
//               vtok               - voltage and temperature both valid
//               dvdd, dgnd         - supply pins, no logic function
// Revision    : 1.0 - initial release
// ============================================================================
module batcharger_adc_sequencer
    import batcharger_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rstz,
    input  logic             en,
    input  logic             vmonen,
    input  logic             imonen,
    input  logic             tmonen,
    input  logic             comp,
    output logic [1:0]       chsel,
    output logic             sample,
    output logic [ADC_W-1:0] dac,
    output logic             eoc,
    output logic [ADC_W-1:0] vbat,
    output logic [ADC_W-1:0] ibat,
    output logic [ADC_W-1:0] tbat,
    output logic             vtok,
    inout  wire              dvdd,
    inout  wire              dgnd
);

    localparam logic [3:0] c_cnt_last = 4'(SETTLE_CYCLES - 1);

    state_e           state_q,  state_d;
    logic [1:0]       chsel_q,  chsel_d;
    logic [3:0]       cnt_q,    cnt_d;
    logic [ADC_W-1:0] vbat_q,   vbat_d;
    logic [ADC_W-1:0] ibat_q,   ibat_d;
    logic [ADC_W-1:0] tbat_q,   tbat_d;
    logic             eoc_q,    eoc_d;
    logic             vvalid_q, vvalid_d;
    logic             ivalid_q, ivalid_d;
    logic             tvalid_q, tvalid_d;
    logic             vtok_q,   vtok_d;

    logic [2:0]       w_mask;
    logic             w_any_en;
    logic             w_active_en;
    logic             w_store;
    logic             w_sar_start;
    logic             w_sar_clr;
    logic             w_sar_done;
    logic [ADC_W-1:0] w_sar_result;

    wire unused_supply;
    assign unused_supply = dvdd ^ dgnd;

    assign w_mask      = {tmonen, imonen, vmonen};
    assign w_any_en    = |w_mask;
    assign w_active_en = ch_enabled(chsel_q, w_mask);

    batcharger_sar_core u_sar (
        .clk    (clk),
        .rst_n  (rstz),
        .start  (w_sar_start),
        .clr    (w_sar_clr),
        .comp   (comp),
        .dac    (dac),
        .result (w_sar_result),
        .done   (w_sar_done)
    );

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state_q  <= IDLE;
            chsel_q  <= CH_V;
            cnt_q    <= '0;
            vbat_q   <= '0;
            ibat_q   <= '0;
            tbat_q   <= '0;
            eoc_q    <= 1'b0;
            vvalid_q <= 1'b0;
            ivalid_q <= 1'b0;
            tvalid_q <= 1'b0;
            vtok_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            chsel_q  <= chsel_d;
            cnt_q    <= cnt_d;
            vbat_q   <= vbat_d;
            ibat_q   <= ibat_d;
            tbat_q   <= tbat_d;
            eoc_q    <= eoc_d;
            vvalid_q <= vvalid_d;
            ivalid_q <= ivalid_d;
            tvalid_q <= tvalid_d;
            vtok_q   <= vtok_d;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_d     = state_q;
        chsel_d     = chsel_q;
        cnt_d       = cnt_q;
        w_sar_start = 1'b0;
        w_sar_clr   = 1'b0;
        if (!en) begin
            state_d   = IDLE;
            cnt_d     = '0;
            w_sar_clr = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_any_en) begin
                        state_d = SELECT;
                        // Searching after T makes V the first candidate
                        chsel_d = next_channel(CH_T, w_mask);
                        cnt_d   = '0;
                    end
                end
                SELECT, CONVERT: begin
                    if (!w_active_en) begin
                        // Active channel lost its enable: abandon, no store
                        w_sar_clr = 1'b1;
                        cnt_d     = '0;
                        if (w_any_en) begin
                            state_d = SELECT;
                            chsel_d = next_channel(chsel_q, w_mask);
                        end else begin
                            state_d = IDLE;
                        end
                    end else if (state_q == SELECT) begin
                        if (cnt_q == c_cnt_last) begin
                            state_d     = CONVERT;
                            w_sar_start = 1'b1;
                            cnt_d       = '0;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end else if (w_sar_done) begin
                        state_d = STORE;
                    end
                end
                STORE: begin
                    cnt_d = '0;
                    if (w_any_en) begin
                        state_d = SELECT;
                        chsel_d = next_channel(chsel_q, w_mask);
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        w_store  = (state_q == STORE) && en;
        sample   = (state_q == SELECT);
        eoc_d    = w_store;
        vbat_d   = (w_store && chsel_q == CH_V) ? w_sar_result : vbat_q;
        ibat_d   = (w_store && chsel_q == CH_I) ? w_sar_result : ibat_q;
        tbat_d   = (w_store && chsel_q == CH_T) ? w_sar_result : tbat_q;
        // A flag survives only while its channel and the block stay enabled
        vvalid_d = en && vmonen && (vvalid_q || (w_store && chsel_q == CH_V));
        ivalid_d = en && imonen && (ivalid_q || (w_store && chsel_q == CH_I));
        tvalid_d = en && tmonen && (tvalid_q || (w_store && chsel_q == CH_T));
        vtok_d   = vvalid_q && tvalid_q && vmonen && tmonen && en;
    end

    assign chsel = chsel_q;
    assign eoc   = eoc_q;
    assign vbat  = vbat_q;
    assign ibat  = ibat_q;
    assign tbat  = tbat_q;
    assign vtok  = vtok_q;

endmodule
`default_nettype wire

// File: tb/tb_batcharger_adc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_batcharger_adc_sequencer
// Description : Self-checking bench for batcharger_adc_sequencer. The
//               comparator is modelled as Vin(chsel) >= dac, so an ideal SAR
//               returns Vin exactly; channel rotation, conversion length and
//               vtok are predicted from the enabled-channel set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_batcharger_adc_sequencer;

    localparam int SETTLE   = 4;
    localparam int CONV_LEN = SETTLE + 9;

    logic       clk;
    logic       rstz;
    logic       en;
    logic       vmonen;
    logic       imonen;
    logic       tmonen;
    logic       comp;
    logic [1:0] chsel;
    logic       sample;
    logic [7:0] dac;
    logic       eoc;
    logic [7:0] vbat;
    logic [7:0] ibat;
    logic [7:0] tbat;
    logic       vtok;
    wire        dvdd;
    wire        dgnd;

    assign dvdd = 1'b1;
    assign dgnd = 1'b0;

    logic [7:0] vin   [0:2];
    logic [7:0] m_reg [0:2];

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0] vv;
        logic [7:0] vi;
        logic [7:0] vt;
        logic [2:0] mask;
        int         nconv;
        logic [7:0] exp_v;
        logic [7:0] exp_i;
        logic [7:0] exp_t;
        logic       exp_vtok;
    } vec_t;

    vec_t tbl [0:3];

    batcharger_adc_sequencer #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk    (clk),
        .rstz   (rstz),
        .en     (en),
        .vmonen (vmonen),
        .imonen (imonen),
        .tmonen (tmonen),
        .comp   (comp),
        .chsel  (chsel),
        .sample (sample),
        .dac    (dac),
        .eoc    (eoc),
        .vbat   (vbat),
        .ibat   (ibat),
        .tbat   (tbat),
        .vtok   (vtok),
        .dvdd   (dvdd),
        .dgnd   (dgnd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        case (chsel)
            2'b00:   comp = (vin[0] >= dac);
            2'b01:   comp = (vin[1] >= dac);
            2'b10:   comp = (vin[2] >= dac);
            default: comp = 1'b0;
        endcase
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_regs(input string name);
        check({name, "_vbat"}, 32'(vbat), 32'(m_reg[0]));
        check({name, "_ibat"}, 32'(ibat), 32'(m_reg[1]));
        check({name, "_tbat"}, 32'(tbat), 32'(m_reg[2]));
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_chsel"},  32'(chsel),  0);
        check({name, "_sample"}, 32'(sample), 0);
        check({name, "_dac"},    32'(dac),    0);
        check({name, "_eoc"},    32'(eoc),    0);
        check({name, "_vbat"},   32'(vbat),   0);
        check({name, "_ibat"},   32'(ibat),   0);
        check({name, "_tbat"},   32'(tbat),   0);
        check({name, "_vtok"},   32'(vtok),   0);
    endtask

    // Next enabled channel in cyclic V(0) -> I(1) -> T(2) order
    function automatic int model_next(input int cur, input logic [2:0] mask);
        for (int s = 1; s <= 3; s++) begin
            if (mask[(cur + s) % 3]) return (cur + s) % 3;
        end
        return cur;
    endfunction

    // Start from IDLE with the given inputs and follow nconv conversions
    task automatic run_conv(input logic [7:0] vv, input logic [7:0] vi, input logic [7:0] vt,
                            input logic [2:0] mask, input int nconv);
        int         exp_ch;
        int         waited;
        logic [2:0] stored;
        logic [1:0] prev_ch;
        logic       prev_sample;
        logic       got_first;
        logic [7:0] first_dac;
        en = 1'b0;
        tick;
        tick;
        check("idle_vtok", 32'(vtok), 0);
        vin[0] = vv;
        vin[1] = vi;
        vin[2] = vt;
        {tmonen, imonen, vmonen} = mask;
        en     = 1'b1;
        exp_ch = 2;
        stored = 3'b000;
        for (int k = 0; k < nconv; k++) begin
            exp_ch    = model_next(exp_ch, mask);
            waited    = 0;
            got_first = 1'b0;
            first_dac = 8'h00;
            prev_ch   = chsel;
            do begin
                prev_sample = sample;
                prev_ch     = chsel;
                tick;
                waited++;
                if (prev_sample && !sample && !got_first) begin
                    first_dac = dac;
                    got_first = 1'b1;
                end
            end while (!eoc && waited < 40);
            check("eoc_interval", 32'(waited), (k == 0) ? 32'(CONV_LEN + 1) : 32'(CONV_LEN));
            check("msb_trial",    32'(first_dac), 32'h80);
            check("chsel_seq",    32'(prev_ch), 32'(exp_ch));
            check("vtok_at_eoc",  32'(vtok), 32'(stored[0] & stored[2]));
            stored[exp_ch] = 1'b1;
            m_reg[exp_ch]  = vin[exp_ch];
            check_regs("store");
        end
        tick;
        check("vtok_after", 32'(vtok), 32'(stored[0] & stored[2]));
    endtask

    initial begin
        int         waited;
        logic       seen;
        logic [2:0] rmask;

        rstz   = 1'b0;
        en     = 1'b0;
        vmonen = 1'b0;
        imonen = 1'b0;
        tmonen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vin[i]   = 8'h00;
            m_reg[i] = 8'h00;
        end
        repeat (3) tick;
        check_all_zero("rst");

        // Out of reset but disabled: nothing may happen
        rstz = 1'b1;
        seen = 1'b0;
        repeat (50) begin
            tick;
            if (eoc) seen = 1'b1;
        end
        check("disabled_eoc", 32'(seen), 0);
        check_all_zero("disabled");

        // Directed table: inputs plus hand-derived final register values
        tbl[0] = '{8'h99, 8'h66, 8'h64, 3'b111, 4, 8'h99, 8'h66, 8'h64, 1'b1};
        tbl[1] = '{8'h00, 8'h00, 8'h00, 3'b111, 3, 8'h00, 8'h00, 8'h00, 1'b1};
        tbl[2] = '{8'hFF, 8'hFF, 8'hFF, 3'b111, 3, 8'hFF, 8'hFF, 8'hFF, 1'b1};
        tbl[3] = '{8'h3C, 8'h33, 8'hC5, 3'b101, 4, 8'h3C, 8'hFF, 8'hC5, 1'b1};
        for (int r = 0; r < 4; r++) begin
            run_conv(tbl[r].vv, tbl[r].vi, tbl[r].vt, tbl[r].mask, tbl[r].nconv);
            check("tbl_vbat", 32'(vbat), 32'(tbl[r].exp_v));
            check("tbl_ibat", 32'(ibat), 32'(tbl[r].exp_i));
            check("tbl_tbat", 32'(tbat), 32'(tbl[r].exp_t));
            check("tbl_vtok", 32'(vtok), 32'(tbl[r].exp_vtok));
        end

        // Random channel sets and input levels
        for (int r = 0; r < 8; r++) begin
            rmask = 3'($urandom_range(1, 7));
            run_conv(8'($urandom), 8'($urandom), 8'($urandom), rmask, int'($urandom_range(2, 5)));
        end

        // en dropped during CONVERT bit 3
        vin[0] = 8'h99;
        vin[1] = 8'h66;
        vin[2] = 8'h64;
        {tmonen, imonen, vmonen} = 3'b111;
        en = 1'b0;
        tick;
        tick;
        en = 1'b1;
        waited = 0;
        while (!vtok && waited < 60) begin
            tick;
            waited++;
        end
        check("drop_pre_vtok", 32'(vtok), 1);
        m_reg[0] = 8'h99;
        m_reg[1] = 8'h66;
        m_reg[2] = 8'h64;
        vin[0]   = 8'h5A;
        waited = 0;
        while (sample && waited < 20) begin
            tick;
            waited++;
        end
        repeat (4) tick;
        check("drop_bit3_dac", 32'(dac), 32'h58);
        en = 1'b0;
        tick;
        check("drop_sample", 32'(sample), 0);
        check("drop_dac",    32'(dac),    0);
        check("drop_eoc",    32'(eoc),    0);
        check("drop_vtok",   32'(vtok),   0);
        check_regs("drop");
        seen = 1'b0;
        repeat (20) begin
            tick;
            if (eoc || dac != 8'h00) seen = 1'b1;
        end
        check("drop_quiet", 32'(seen), 0);
        check_regs("drop_hold");

        // Asynchronous reset between edges while in SELECT of the current channel
        en = 1'b1;
        waited = 0;
        while (!(sample && chsel == 2'b01) && waited < 60) begin
            tick;
            waited++;
        end
        check("ar_in_select", 32'({sample, chsel}), 32'b101);
        #2;
        rstz = 1'b0;
        #1;
        check_all_zero("async_rst");
        #10;
        rstz = 1'b1;
        en   = 1'b0;
        tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/batcharger_adc_sequencer.md
# batcharger_adc_sequencer

Measurement front-end for the battery charger. It time-multiplexes one 8-bit SAR ADC (analog mux, S/H, DAC, comparator) across battery voltage, current and temperature. It produces the `vbat`, `ibat` and `tbat` codes and the `vtok` valid flag that `BATCHARGER_controller` consumes. The monitor enables it receives are driven back by the controller.

## Interface
- `SETTLE_CYCLES`, default 4: cycles spent sampling with `sample`=1 after each mux switch; legal range 1..15.
- `clk`  in  1  state machine clock, same clock as the controller
- `rstz`  in  1  system reset; asynchronous, active-low
- `en`  in  1  block enable
- `vmonen`  in  1  voltage channel enable (from controller)
- `imonen`  in  1  current channel enable (from controller)
- `tmonen`  in  1  temperature channel enable (from controller)
- `comp`  in  1  comparator output; 1 when Vin ≥ Vdac
- `chsel`  out  2  analog mux select: 00 voltage, 01 current, 10 temperature
- `sample`  out  1  S/H track control
- `dac`  out  8  SAR DAC trial code
- `eoc`  out  1  one-cycle end-of-conversion pulse
- `vbat`  out  8  last stored voltage code
- `ibat`  out  8  last stored current code
- `tbat`  out  8  last stored temperature code
- `vtok`  out  1  voltage and temperature codes are both valid
- `dvdd`, `dgnd`  inout  1  digital supply and ground; no logic function

## Operation
- States:
  - IDLE: entered from reset.
  - SELECT: `sample`=1 for `SETTLE_CYCLES` cycles.
  - CONVERT: 8 cycles, bit 7 down to bit 0.
  - STORE: 1 cycle.
- IDLE → SELECT on the first edge where `en`=1 and at least one monen is 1.
- Channel order is voltage → current → temperature, then wrap to voltage. Disabled channels are skipped.
- `chsel` is updated on entry to SELECT and held until the next SELECT.
- CONVERT, bit k:
  - `dac` = result | (1<<k).
  - On the closing edge, if `comp`=1 the bit is kept; otherwise it is cleared.
- STORE:
  - The result is written to the selected output register.
  - `eoc`=1 for one cycle.
  - The channel's valid flag is set.
  - Next state is SELECT of the next enabled channel, or IDLE if none are enabled.
- Outside CONVERT, `dac`=0. Outside SELECT, `sample`=0.
- `vtok` is registered: `vtok` = vvalid & tvalid & `vmonen` & `tmonen` & `en`.
- A channel's valid flag clears when its monen=0 or `en`=0.
- `en` falls in any state: the block is in IDLE on the next edge. The partial result is discarded, output code registers hold their values, and valid flags clear.
- The active channel's monen falls during SELECT or CONVERT: that conversion is abandoned on the next edge and the block moves to SELECT of the next enabled channel. No store is done.
- All monen low: the block finishes to IDLE via the abandon path.
- Codes 0x00 and 0xFF are reachable. No saturation or offset is applied.

## Timing
- Reset values: state IDLE, `chsel`=00, `sample`=0, `dac`=0x00, `eoc`=0, `vbat`=`ibat`=`tbat`=0x00, `vtok`=0, valid flags 0.
- Conversion length: `SETTLE_CYCLES` + 8 + 1 cycles, which is 13 cycles at the default setting.
- First SELECT cycle is the cycle after the edge that sampled `en`=1.
- Output registers and `eoc` change on the STORE edge.
- `vtok` rises on the edge after the later of the voltage or temperature store.
- Asynchronous reset mid-operation forces all reset values immediately, with no clock required.

## Structure
- Package `batcharger_pkg`:
  - state enum (IDLE, SELECT, CONVERT, STORE)
  - channel encoding constants CH_V=2'b00, CH_I=2'b01, CH_T=2'b10
  - ADC width constant 8
- Sub-module `batcharger_sar_core`:
  - 8-bit result register, bit pointer and DAC trial logic
  - ports: `start`, `comp`, `dac`, `result`, `done`, `clr`
- Top level holds the sequencer FSM, settle counter, output registers and valid flags.

## Test plan
The bench models `comp` = (Vin(`chsel`) ≥ `dac`).

- Reset held, then `rstz`=1 with `en`=0 → all outputs 0, `chsel` 00, no `eoc` for 50 cycles.
- `en`=1, all monen=1, Vin V/I/T = 0x99/0x66/0x64:
  - `eoc` appears every 13 cycles.
  - `chsel` sequence is 00, 01, 10, 00.
  - `vbat`=0x99, `ibat`=0x66, `tbat`=0x64.
  - `vtok` rises one cycle after the third `eoc`.
- Vin = 0x00 and 0xFF on all channels → exact codes; `dac` trial for bit 7 is 0x80.
- `imonen`=0 → `chsel` alternates 00/10, `ibat` holds its prior value, `vtok` still rises.
- `en` dropped during CONVERT bit 3 → IDLE next edge, `dac`=0, `vtok`=0, no `eoc`, registers unchanged.
- `rstz` asserted mid-SELECT between clock edges → outputs zero before the next clock edge.
